// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing a shared-memory datapath.
// Optional BNE support is enabled by defining MC_BNE_EN.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immtype,
    output logic [1:0] pcsrc,
    output logic [3:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IEXEC   = 4'd9,
        S_IWB     = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    state_t     r_state;
    state_t     w_next;
    logic       w_funct_ok;
    logic [3:0] w_funct_alu;
    logic       w_pcwrite, w_branch, w_branch_ne;
    logic       w_irwrite, w_memwrite, w_regwrite, w_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = ALU_ADD;
        case (funct)
            6'b100000: w_funct_alu = ALU_ADD;
            6'b100010: w_funct_alu = ALU_SUB;
            6'b100100: w_funct_alu = ALU_AND;
            6'b100101: w_funct_alu = ALU_OR;
            6'b101010: w_funct_alu = ALU_SLT;
            6'b100111: w_funct_alu = ALU_NOR;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_next      = S_FETCH;
        w_pcwrite   = 1'b0;
        w_branch    = 1'b0;
        w_branch_ne = 1'b0;
        w_irwrite   = 1'b0;
        w_memwrite  = 1'b0;
        w_regwrite  = 1'b0;
        w_illegal   = 1'b0;
        iord        = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        immtype     = 2'b00;
        pcsrc       = 2'b00;
        alucontrol  = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                alusrcb   = 2'b01;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE: begin
                        w_next    = w_funct_ok ? S_EXECUTE : S_FETCH;
                        w_illegal = ~w_funct_ok;
                    end
                    OP_BEQ: w_next = S_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE: w_next = S_BRANCH;
`endif
                    OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: w_next = S_IEXEC;
                    OP_J: w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
                w_next     = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = w_funct_alu;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
`ifdef MC_BNE_EN
                w_branch_ne = (op == OP_BNE);
                w_branch    = (op != OP_BNE);
`else
                w_branch    = 1'b1;
`endif
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = S_IWB;
                case (op)
                    OP_ORI:  begin immtype = 2'b01; alucontrol = ALU_OR;  end
                    OP_ANDI: begin immtype = 2'b01; alucontrol = ALU_AND; end
                    OP_LUI:  begin immtype = 2'b10; alucontrol = ALU_OR;  end
                    default: begin immtype = 2'b00; alucontrol = ALU_ADD; end
                endcase
            end
            S_IWB: w_regwrite = 1'b1;
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset already forces FETCH, which would otherwise fetch while held in reset.
    assign irwrite  = w_irwrite  & ~reset;
    assign memwrite = w_memwrite & ~reset;
    assign regwrite = w_regwrite & ~reset;
    assign illegal  = w_illegal  & ~reset;
    assign pcen     = (w_pcwrite | (w_branch & zero) | (w_branch_ne & ~zero)) & ~reset;
    assign state    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through its state
// sequence and checks decoded controls, stalls, reset and illegal-op handling.
module tb_mc_controller;
    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] op, funct;
    logic       pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca, illegal;
    logic [1:0] alusrcb, immtype, pcsrc;
    logic [3:0] alucontrol, state;
    int         checks = 0;
    int         failures = 0;
    int         wr_cycles;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite),
        .iord(iord), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .immtype(immtype), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0;
        #2;
        chk("rst_state", state, 0);
        mem_ready = 1'b1;
        #1;
        chk("rst_irwrite", irwrite, 0);
        chk("rst_pcen", pcen, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("fetch_irwrite", irwrite, 1);
        chk("fetch_pcen", pcen, 1);
        chk("fetch_alusrcb", alusrcb, 2'b01);

        // LW: 0,1,2,3,4,0
        op = 6'b100011;
        tick(); chk("lw_s1", state, 1); chk("lw_dec_alusrcb", alusrcb, 2'b11);
        tick(); chk("lw_s2", state, 2); chk("lw_adr_alusrcb", alusrcb, 2'b10);
        tick(); chk("lw_s3", state, 3); chk("lw_rd_iord", iord, 1);
        chk("lw_rd_regwrite", regwrite, 0);
        tick(); chk("lw_s4", state, 4); chk("lw_wb_regwrite", regwrite, 1);
        chk("lw_wb_memtoreg", memtoreg, 1);
        tick(); chk("lw_s0", state, 0); chk("lw_fetch_memtoreg", memtoreg, 0);

        // FETCH stall: no writes, no advance
        mem_ready = 1'b0;
        #1;
        chk("fstall_irwrite", irwrite, 0);
        chk("fstall_pcen", pcen, 0);
        tick(); chk("fstall_state", state, 0);
        mem_ready = 1'b1;

        // SW with 3 stall cycles in MEMWR
        op = 6'b101011;
        tick(); tick();
        mem_ready = 1'b0;
        tick(); chk("sw_s5", state, 5);
        wr_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (memwrite) wr_cycles++;
            chk("sw_stall_state", state, 5);
            chk("sw_stall_regwrite", regwrite, 0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        if (memwrite) wr_cycles++;
        chk("sw_iord", iord, 1);
        tick();
        chk("sw_wr_cycles", wr_cycles, 4);
        chk("sw_back_fetch", state, 0);

        // Reset mid-MEMWR while stalled
        tick(); tick();
        mem_ready = 1'b0;
        tick(); chk("sw2_s5", state, 5); chk("sw2_memwrite", memwrite, 1);
        reset = 1'b1;
        #1;
        chk("midrst_state", state, 0);
        chk("midrst_memwrite", memwrite, 0);
        mem_ready = 1'b1;
        tick();
        chk("midrst_hold_irwrite", irwrite, 0);
        reset = 1'b0;
        #1;
        chk("rel_irwrite", irwrite, 1);
        chk("rel_pcen", pcen, 1);

        // BEQ: 3-cycle, pcen follows zero
        op = 6'b000100;
        tick(); chk("beq_s1", state, 1);
        tick(); chk("beq_s8", state, 8);
        zero = 1'b1; #1;
        chk("beq_z1_pcen", pcen, 1);
        chk("beq_pcsrc", pcsrc, 2'b01);
        chk("beq_aluctl", alucontrol, 4'b0110);
        zero = 1'b0; #1;
        chk("beq_z0_pcen", pcen, 0);
        tick(); chk("beq_s0", state, 0);

        // R-type NOR
        op = 6'b000000; funct = 6'b100111;
        tick(); tick(); chk("r_s6", state, 6);
        chk("r_aluctl", alucontrol, 4'b1100);
        chk("r_alusrca", alusrca, 1);
        tick(); chk("r_s7", state, 7); chk("r_regdst", regdst, 1);
        chk("r_regwrite", regwrite, 1);
        tick(); chk("r_s0", state, 0);

        // R-type illegal funct
        funct = 6'b000000;
        tick(); chk("rill_s1", state, 1); chk("rill_illegal", illegal, 1);
        tick(); chk("rill_s0", state, 0); chk("rill_clear", illegal, 0);

        // ORI
        op = 6'b001101;
        tick(); chk("ori_dec_illegal", illegal, 0);
        tick(); chk("ori_s9", state, 9);
        chk("ori_immtype", immtype, 2'b01); chk("ori_aluctl", alucontrol, 4'b0001);
        tick(); chk("ori_s10", state, 10); chk("ori_regwrite", regwrite, 1);
        chk("ori_regdst", regdst, 0);
        tick(); chk("ori_s0", state, 0);

        // LUI
        op = 6'b001111;
        tick(); tick(); chk("lui_s9", state, 9);
        chk("lui_immtype", immtype, 2'b10); chk("lui_aluctl", alucontrol, 4'b0001);
        tick(); tick(); chk("lui_s0", state, 0);

        // Op 000101: illegal unless BNE is built in
        op = 6'b000101;
        tick(); chk("bne_s1", state, 1);
`ifdef MC_BNE_EN
        chk("bne_illegal", illegal, 0);
        tick(); chk("bne_s8", state, 8);
        zero = 1'b0; #1; chk("bne_z0_pcen", pcen, 1);
        zero = 1'b1; #1; chk("bne_z1_pcen", pcen, 0);
        zero = 1'b0;
        tick(); chk("bne_s0", state, 0);
`else
        chk("bne_illegal", illegal, 1);
        tick(); chk("bne_s0", state, 0);
`endif

        // J
        op = 6'b000010;
        tick(); tick(); chk("j_s11", state, 11);
        chk("j_pcen", pcen, 1); chk("j_pcsrc", pcsrc, 2'b10);
        tick(); chk("j_s0", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle MIPS control unit: a Moore state machine that sequences a shared-memory multicycle datapath (single ALU, single memory, instruction register, A/B/ALUOut/Data registers) through fetch, decode, execute, memory and writeback steps. It supports the same instruction set as the single-cycle control unit and drives the datapath's enables and multiplexer selects each cycle. A memory-ready handshake lets slow memory stretch the memory-access states.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; state forced to FETCH
- op  in  6  instr[31:26] from instruction register (stable after FETCH)
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- pcen  out  1  PC load enable
- irwrite  out  1  instruction register load
- memwrite  out  1  memory write strobe
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- regwrite  out  1  register file write
- regdst  out  1  write register: 0 = rt, 1 = rd
- memtoreg  out  1  writeback data: 0 = ALUOut, 1 = Data
- alusrca  out  1  ALU A: 0 = PC, 1 = A
- alusrcb  out  2  ALU B: 00 = B, 01 = 4, 10 = ext imm, 11 = sign imm << 2
- immtype  out  2  00 = sign-extend, 01 = zero-extend, 10 = imm << 16
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1100 nor
- illegal  out  1  one-cycle pulse: undefined op/funct detected in DECODE
- state  out  4  current state encoding (debug)

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11; codes 12-15 go to FETCH.
- Unlisted outputs are 0 in every state; alucontrol defaults to 0010, immtype to 00.
- FETCH: iord 0, alusrca 0, alusrcb 01, pcsrc 00; irwrite = pcwrite = mem_ready; stay until mem_ready, then DECODE.
- DECODE: alusrca 0, alusrcb 11 (branch target into ALUOut). Next: LW/SW -> MEMADR; R-type -> EXECUTE; BEQ -> BRANCH; ADDI/ORI/ANDI/LUI -> IEXEC; J -> JUMP; anything else (incl. R-type with funct outside the six supported) -> FETCH with illegal = 1.
- MEMADR: alusrca 1, alusrcb 10, immtype 00; LW -> MEMRD, SW -> MEMWR.
- MEMRD: iord 1; hold until mem_ready, then MEMWB.
- MEMWB: regdst 0, memtoreg 1, regwrite 1 -> FETCH.
- MEMWR: iord 1, memwrite 1 held asserted until mem_ready, then FETCH.
- EXECUTE: alusrca 1, alusrcb 00, alucontrol decoded from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 100111 nor) -> ALUWB.
- ALUWB: regdst 1, memtoreg 0, regwrite 1 -> FETCH.
- BRANCH: alusrca 1, alusrcb 00, alucontrol 0110, pcsrc 01, branch internal = 1 -> FETCH.
- IEXEC: alusrca 1, alusrcb 10; ADDI: immtype 00/add; ORI: 01/or; ANDI: 01/and; LUI: 10/or -> IWB.
- IWB: regdst 0, memtoreg 0, regwrite 1 -> FETCH.
- JUMP: pcsrc 10, pcwrite 1 -> FETCH.
- pcen = pcwrite | (branch & zero).

## Timing
- All outputs except pcen are decoded from registered state plus op/funct/mem_ready; pcen additionally combinational on zero.
- With mem_ready held 1: LW 5 cycles; SW, R-type, I-type 4; BEQ, J 3.
- Each cycle of mem_ready = 0 in FETCH/MEMRD/MEMWR adds one cycle; no writes (irwrite, pcwrite, regwrite) occur while stalled.
- Reset asserted: state = FETCH immediately; irwrite, pcen, memwrite, regwrite, illegal forced 0 while reset is high, even mid-instruction or mid-stall. First fetch completes on the first edge after deassertion where mem_ready = 1.
- illegal asserts only during the DECODE cycle.

## Configuration
- MC_BNE_EN defined: opcode 000101 (BNE) decodes to BRANCH; internal branch_ne set there; pcen = pcwrite | (branch & zero) | (branch_ne & ~zero).
- Undefined: 000101 is illegal (DECODE -> FETCH, illegal pulse).

## Test plan
- Reset mid-MEMWR with mem_ready 0 -> state 0 at once, memwrite 0; after release, FETCH with mem_ready 1 gives irwrite = pcen = 1.
- LW (op 100011), mem_ready 1 -> states 0,1,2,3,4,0; regwrite and memtoreg 1 only in state 4.
- SW with mem_ready low 3 cycles in MEMWR -> memwrite high 4 cycles, then FETCH.
- BEQ zero=1 -> pcen 1 in BRANCH with pcsrc 01; zero=0 -> pcen 0; 3-cycle sequence.
- R-type funct 100111 -> alucontrol 1100 in EXECUTE, regdst 1 in ALUWB; funct 000000 -> illegal pulse, back to FETCH.
- ORI/LUI -> immtype 01/10, alucontrol 0001 in IEXEC; op 000101 illegal without MC_BNE_EN, branches on zero=0 with it.
